// File: rtl/tx_time_scheduler.sv
// Timed-release scheduler: owns the 32-bit sample-time counter and releases, late-releases or drops the head TX packet.
// Define TX_TIME_SCHED_STATS_EN to add saturating late/drop counters cleared by stats_clear.
module tx_time_scheduler #(
  parameter int unsigned JITTER       = 4,
  parameter logic [31:0] IMMEDIATE_TS = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        time_set,
  input  logic [31:0] time_load_val,
  output logic [31:0] time_now,
  input  logic        pkt_valid,
  input  logic [31:0] pkt_timestamp,
  output logic        pkt_ack,
  output logic        tx_start,
  input  logic        tx_done,
  output logic        late_pulse,
  output logic        drop_pulse,
  output logic        busy
`ifdef TX_TIME_SCHED_STATS_EN
  ,
  input  logic        stats_clear,
  output logic [15:0] late_count,
  output logic [15:0] drop_count
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_EVAL    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_SENDING = 3'd4;
  localparam logic [2:0] S_DROP    = 3'd5;

  logic [2:0]  r_state;
  logic [31:0] r_time;
  logic [31:0] r_ts;
  logic        r_tx_start;
  logic        r_pkt_ack;
  logic        r_late;
  logic        r_drop;
  logic        r_busy;

  logic [2:0]  w_next;
  logic        w_late_rel;
  logic [31:0] w_slack;
  logic [31:0] w_late_by;
  logic        w_on_time;
  logic        w_ahead;
  logic        w_in_jitter;
  logic        w_immediate;

  // Slack is measured against the cycle in which tx_start would actually be high.
  assign w_slack     = r_ts - (r_time + 32'd1);
  assign w_late_by   = 32'd0 - w_slack;
  assign w_on_time   = (w_slack == 32'd0);
  assign w_ahead     = ~w_slack[31];
  assign w_in_jitter = w_slack[31] && (w_late_by <= 32'(JITTER));
  assign w_immediate = (r_ts == IMMEDIATE_TS);

  always_comb begin
    w_next     = r_state;
    w_late_rel = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (pkt_valid) w_next = S_EVAL;
      end
      S_EVAL: begin
        if (w_immediate || w_on_time) begin
          w_next = S_RELEASE;
        end else if (w_ahead) begin
          w_next = S_WAIT;
        end else if (w_in_jitter) begin
          w_next     = S_RELEASE;
          w_late_rel = 1'b1;
        end else begin
          w_next = S_DROP;
        end
      end
      S_WAIT: begin
        // A time jump invalidates the wait, so the timestamp is judged afresh.
        if (time_set) w_next = S_EVAL;
        else if (w_on_time) w_next = S_RELEASE;
      end
      S_RELEASE: w_next = S_SENDING;
      S_SENDING: begin
        if (tx_done) w_next = S_IDLE;
      end
      S_DROP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_time     <= 32'd0;
      r_state    <= S_IDLE;
      r_ts       <= 32'd0;
      r_tx_start <= 1'b0;
      r_pkt_ack  <= 1'b0;
      r_late     <= 1'b0;
      r_drop     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_time     <= time_set ? time_load_val : r_time + 32'd1;
      r_state    <= w_next;
      if (r_state == S_IDLE && pkt_valid) r_ts <= pkt_timestamp;
      r_tx_start <= (w_next == S_RELEASE);
      r_pkt_ack  <= (w_next == S_RELEASE) || (w_next == S_DROP);
      r_late     <= w_late_rel;
      r_drop     <= (w_next == S_DROP);
      r_busy     <= (w_next != S_IDLE);
    end
  end

  assign time_now   = r_time;
  assign tx_start   = r_tx_start;
  assign pkt_ack    = r_pkt_ack;
  assign late_pulse = r_late;
  assign drop_pulse = r_drop;
  assign busy       = r_busy;

`ifdef TX_TIME_SCHED_STATS_EN
  logic [15:0] r_late_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (reset || stats_clear) begin
      r_late_cnt <= 16'd0;
      r_drop_cnt <= 16'd0;
    end else begin
      if (r_late && r_late_cnt != 16'hFFFF) r_late_cnt <= r_late_cnt + 16'd1;
      if (r_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign late_count = r_late_cnt;
  assign drop_count = r_drop_cnt;
`endif

endmodule

// File: tb/tb_tx_time_scheduler.sv
// Randomized bench for tx_time_scheduler: per-packet outcome predicted from timestamp rules, outputs checked every cycle.
module tb_tx_time_scheduler;

  localparam int JIT    = 4;
  localparam int K_REL  = 0;
  localparam int K_LATE = 1;
  localparam int K_DROP = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        time_set;
  logic [31:0] time_load_val;
  logic [31:0] time_now;
  logic        pkt_valid;
  logic [31:0] pkt_timestamp;
  logic        pkt_ack;
  logic        tx_start;
  logic        tx_done;
  logic        late_pulse;
  logic        drop_pulse;
  logic        busy;
`ifdef TX_TIME_SCHED_STATS_EN
  logic        stats_clear;
  logic [15:0] late_count;
  logic [15:0] drop_count;
`endif

  int total = 0;
  int bad   = 0;
  int n_late = 0;
  int n_drop = 0;
  logic [31:0] m_time;

  tx_time_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .time_set      (time_set),
    .time_load_val (time_load_val),
    .time_now      (time_now),
    .pkt_valid     (pkt_valid),
    .pkt_timestamp (pkt_timestamp),
    .pkt_ack       (pkt_ack),
    .tx_start      (tx_start),
    .tx_done       (tx_done),
    .late_pulse    (late_pulse),
    .drop_pulse    (drop_pulse),
    .busy          (busy)
`ifdef TX_TIME_SCHED_STATS_EN
    ,
    .stats_clear   (stats_clear),
    .late_count    (late_count),
    .drop_count    (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference sample-time counter.
  always @(posedge clk) begin
    if (reset) m_time <= 32'd0;
    else if (time_set) m_time <= time_load_val;
    else m_time <= m_time + 32'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {busy, pkt_ack, tx_start, late_pulse, drop_pulse}
  function automatic logic [31:0] outs();
    return {27'd0, busy, pkt_ack, tx_start, late_pulse, drop_pulse};
  endfunction

  function automatic logic [31:0] pulse_vec(input int kind);
    if (kind == K_DROP) return 32'b11001;
    if (kind == K_LATE) return 32'b11110;
    return 32'b11100;
  endfunction

  // Outcome of judging ts when the decision cycle shows time e; the earliest start is at e+1.
  task automatic predict(input logic [31:0] ts, input logic [31:0] e,
                         output int kind, output logic [31:0] when);
    int     slack;
    longint lateness;
    slack    = $signed(ts - e - 32'd1);
    lateness = -longint'(slack);
    when     = e + 32'd1;
    if (ts == 32'hFFFF_FFFF) kind = K_REL;
    else if (slack >= 0) begin kind = K_REL; when = ts; end
    else if (lateness <= JIT) kind = K_LATE;
    else kind = K_DROP;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [31:0] v);
    time_set = 1'b1;
    time_load_val = v;
    tick();
    time_set = 1'b0;
    chk("set_time", time_now, v);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tx_done = ($urandom_range(0, 1) == 1);
      tick();
      tx_done = 1'b0;
      chk("idle_outs", outs(), 32'd0);
      chk("idle_time", time_now, m_time);
    end
  endtask

  task automatic run_pkt(input logic [31:0] ts, input int set_after,
                         input logic [31:0] set_val, input logic done_early);
    int          kind;
    logic [31:0] when;
    logic        hit;
    pkt_valid = 1'b1;
    pkt_timestamp = ts;
    tick();
    pkt_timestamp = $urandom;
    predict(ts, m_time, kind, when);
    chk("eval_outs", outs(), 32'b10000);
    hit = 1'b0;
    for (int k = 0; k < 300 && !hit; k++) begin
      if (k == set_after) begin
        time_set = 1'b1;
        time_load_val = set_val;
      end
      tick();
      time_set = 1'b0;
      if (k == set_after) predict(ts, m_time, kind, when);
      chk("time", time_now, m_time);
      hit = (m_time == when);
      if (hit) chk("pulse_outs", outs(), pulse_vec(kind));
      else chk("wait_outs", outs(), 32'b10000);
    end
    chk("pkt_resolved", {31'd0, hit}, 32'd1);
    pkt_valid = 1'b0;
    if (kind == K_DROP) begin
      n_drop++;
      tick();
      chk("after_drop", outs(), 32'd0);
    end else begin
      if (kind == K_LATE) n_late++;
      tx_done = done_early;
      tick();
      tx_done = 1'b0;
      chk("sending", outs(), 32'b10000);
      repeat ($urandom_range(0, 3)) begin
        tick();
        chk("sending", outs(), 32'b10000);
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("after_done", outs(), 32'd0);
    end
  endtask

  initial begin
    int          kind;
    int          sa;
    logic [31:0] when;
    logic [31:0] ts;
    logic [31:0] sv;
    reset = 1'b1;
    time_set = 1'b0;
    time_load_val = 32'd0;
    pkt_valid = 1'b0;
    pkt_timestamp = 32'd0;
    tx_done = 1'b0;
`ifdef TX_TIME_SCHED_STATS_EN
    stats_clear = 1'b0;
`endif
    repeat (2) tick();
    chk("rst_outs", outs(), 32'd0);
    chk("rst_time", time_now, 32'd0);
    reset = 1'b0;
    tick();
    chk("time_after_rst", time_now, 32'd1);
    idle_cycles(3);

    set_time(32'd3);          run_pkt(32'h10, -1, 0, 1'b0);
    set_time(32'hFFFF_FFFE);  run_pkt(32'h1, -1, 0, 1'b0);
    set_time(32'd6);          run_pkt(32'd5, -1, 0, 1'b0);
    set_time(32'd8);          run_pkt(32'd5, -1, 0, 1'b0);
    set_time(32'd7);          run_pkt(32'd5, -1, 0, 1'b0);
    set_time(32'd3);          run_pkt(32'd4, -1, 0, 1'b0);
    set_time(32'd3);          run_pkt(32'd5, -1, 0, 1'b0);
    set_time(32'd0);          run_pkt(32'h8000_0001, 3, 32'h7FFF_FFF0, 1'b0);
    set_time(32'd0);          run_pkt(32'h8000_0002, -1, 0, 1'b0);
    set_time($urandom);       run_pkt(32'hFFFF_FFFF, -1, 0, 1'b1);
    set_time(32'h50);         run_pkt(32'h100, 2, 32'h200, 1'b0);

    // Reset while the burst engine is sending aborts the packet.
    pkt_valid = 1'b1;
    pkt_timestamp = 32'hFFFF_FFFF;
    tick();
    tick();
    chk("imm_start", outs(), 32'b11100);
    pkt_valid = 1'b0;
    tick();
    chk("imm_sending", outs(), 32'b10000);
    reset = 1'b1;
    n_late = 0;
    n_drop = 0;
    tick();
    reset = 1'b0;
    chk("rst_mid_outs", outs(), 32'd0);
    chk("rst_mid_time", time_now, 32'd0);
    idle_cycles(2);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) set_time(32'hFFFF_FFF0 + $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) ts = 32'hFFFF_FFFF;
      else ts = m_time + $urandom_range(0, 40) - 32'd10;
      sa = -1;
      sv = 32'd0;
      predict(ts, m_time + 32'd1, kind, when);
      if (kind == K_REL && ts != 32'hFFFF_FFFF && (ts - m_time - 32'd1) >= 32'd2
          && $urandom_range(0, 2) == 0) begin
        sa = int'($urandom_range(1, ts - m_time - 32'd2));
        sv = m_time + $urandom_range(0, 60) - 32'd30;
      end
      run_pkt(ts, sa, sv, ($urandom_range(0, 1) == 1));
    end

`ifdef TX_TIME_SCHED_STATS_EN
    chk("late_count", {16'd0, late_count}, n_late);
    chk("drop_count", {16'd0, drop_count}, n_drop);
    stats_clear = 1'b1;
    tick();
    stats_clear = 1'b0;
    chk("late_clear", {16'd0, late_count}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
